// File: rtl/sha512_pkg.sv
// Shared constants, FSM state encoding and length-field helper for the SHA-512 padder.
package sha512_pkg;

  localparam int SHA512_BLOCK_BYTES     = 128;
  localparam int SHA512_LINE_BYTES      = 64;
  localparam int SHA512_LEN_OFFSET      = 112;
  localparam int SHA512_GUARD_CYCLES    = 3;
  localparam int SHA512_ERR_STALL_LIMIT = 256;

  typedef enum logic [2:0] {
    IDLE,
    FILL_HI,
    FILL_LO,
    ISSUE,
    GUARD,
    PAD
  } pad_state_e;

  // Message length in bits as the 128-bit big-endian trailer value.
  function automatic logic [127:0] len_field(input logic [63:0] nbytes);
    return {61'b0, nbytes, 3'b000};
  endfunction

endpackage

// File: rtl/sha512_padder_if.sv
// Line-input and block-output bundle between a message source/hash engine and the padder.
interface sha512_padder_if;

  logic [511:0]      in_data;
  logic              in_valid;
  logic              in_last;
  logic [6:0]        in_bytes;
  logic              in_ready;
  logic [1:0][511:0] block;
  logic              block_valid;
  logic              block_first;
  logic              core_ready;
  logic              msg_done;
  logic              err;

  modport master (
    output in_data, in_valid, in_last, in_bytes, core_ready,
    input  in_ready, block, block_valid, block_first, msg_done, err
  );

  modport slave (
    input  in_data, in_valid, in_last, in_bytes, core_ready,
    output in_ready, block, block_valid, block_first, msg_done, err
  );

endinterface

// File: rtl/sha512_pad_mask.sv
// Keeps the first in_bytes bytes of a line, writes 0x80 right after them and zeroes the rest.
module sha512_pad_mask
  import sha512_pkg::*;
(
  input  logic [511:0] line_i,
  input  logic [6:0]   in_bytes_i,
  output logic [511:0] masked_o
);

  always_comb begin
    masked_o = '0;
    for (int i = 0; i < SHA512_LINE_BYTES; i++) begin
      if (7'(i) < in_bytes_i) begin
        masked_o[511 - 8*i -: 8] = line_i[511 - 8*i -: 8];
      end else if (7'(i) == in_bytes_i) begin
        masked_o[511 - 8*i -: 8] = 8'h80;
      end
    end
  end

endmodule

// File: rtl/sha512_padder.sv
// SHA-512 message padder: packs 64-byte lines into 128-byte blocks, appends 0x80/zeros/length.
// Optional `SHA512_PAD_ERR_EN enables the sticky protocol-error flag.
module sha512_padder
  import sha512_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  sha512_padder_if.slave bus
);

  pad_state_e        state_q, state_d;
  logic [1:0][511:0] work_q, work_d;
  logic [1:0][511:0] block_q, block_d;
  logic [63:0]       len_q, len_d;
  logic              first_q, first_d;
  logic              final_q, final_d;
  logic              pad_q, pad_d;
  logic              pad_lead_q, pad_lead_d;
  logic [1:0]        guard_q, guard_d;
  logic              block_valid_q, block_valid_d;
  logic              block_first_q, block_first_d;
  logic              msg_done_q, msg_done_d;
  logic              in_ready_c;
  logic              accept;
  logic [6:0]        n_eff;
  logic [63:0]       len_sum;
  logic [511:0]      masked;

  assign n_eff   = (bus.in_bytes > 7'd64) ? 7'd64 : bus.in_bytes;
  assign accept  = bus.in_valid && in_ready_c;
  assign len_sum = len_q + {57'b0, n_eff};

  sha512_pad_mask u_mask (
    .line_i     (bus.in_data),
    .in_bytes_i (n_eff),
    .masked_o   (masked)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      work_q        <= '0;
      block_q       <= '0;
      len_q         <= '0;
      first_q       <= 1'b1;
      final_q       <= 1'b0;
      pad_q         <= 1'b0;
      pad_lead_q    <= 1'b0;
      guard_q       <= '0;
      block_valid_q <= 1'b0;
      block_first_q <= 1'b0;
      msg_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      work_q        <= work_d;
      block_q       <= block_d;
      len_q         <= len_d;
      first_q       <= first_d;
      final_q       <= final_d;
      pad_q         <= pad_d;
      pad_lead_q    <= pad_lead_d;
      guard_q       <= guard_d;
      block_valid_q <= block_valid_d;
      block_first_q <= block_first_d;
      msg_done_q    <= msg_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    work_d        = work_q;
    block_d       = block_q;
    len_d         = len_q;
    first_d       = first_q;
    final_d       = final_q;
    pad_d         = pad_q;
    pad_lead_d    = pad_lead_q;
    guard_d       = guard_q;
    block_valid_d = 1'b0;
    block_first_d = 1'b0;
    msg_done_d    = 1'b0;
    in_ready_c    = 1'b0;

    case (state_q)
      IDLE: state_d = FILL_HI;

      FILL_HI: begin
        in_ready_c = 1'b1;
        if (accept) begin
          if (bus.in_last) begin
            // A full 64-byte last line pushes the 0x80 marker into the low half.
            work_d[1] = masked;
            work_d[0] = {(n_eff == 7'd64) ? 8'h80 : 8'h00, 376'b0, len_field(len_sum)};
            len_d     = len_sum;
            final_d   = 1'b1;
            pad_d     = 1'b0;
            state_d   = ISSUE;
          end else begin
            work_d[1] = bus.in_data;
            len_d     = len_q + 64'(SHA512_LINE_BYTES);
            state_d   = FILL_LO;
          end
        end
      end

      FILL_LO: begin
        in_ready_c = 1'b1;
        if (accept) begin
          state_d = ISSUE;
          if (bus.in_last) begin
            len_d = len_sum;
            if (n_eff < 7'(SHA512_LEN_OFFSET - SHA512_LINE_BYTES)) begin
              work_d[0] = masked | {384'b0, len_field(len_sum)};
              final_d   = 1'b1;
              pad_d     = 1'b0;
            end else begin
              // No room for the length field: an extra all-zero block follows.
              work_d[0]  = masked;
              final_d    = 1'b0;
              pad_d      = 1'b1;
              pad_lead_d = (n_eff == 7'd64);
            end
          end else begin
            work_d[0] = bus.in_data;
            len_d     = len_q + 64'(SHA512_LINE_BYTES);
            final_d   = 1'b0;
            pad_d     = 1'b0;
          end
        end
      end

      ISSUE: begin
        if (bus.core_ready) begin
          block_valid_d = 1'b1;
          block_first_d = first_q;
          msg_done_d    = final_q;
          first_d       = final_q;
          guard_d       = '0;
          state_d       = GUARD;
          if (final_q) begin
            len_d   = '0;
            final_d = 1'b0;
          end
        end
      end

      GUARD: begin
        if (guard_q == 2'(SHA512_GUARD_CYCLES - 1)) begin
          state_d = pad_q ? PAD : FILL_HI;
        end else begin
          guard_d = guard_q + 2'd1;
        end
      end

      PAD: begin
        work_d[1]  = {pad_lead_q ? 8'h80 : 8'h00, 504'b0};
        work_d[0]  = {384'b0, len_field(len_q)};
        pad_d      = 1'b0;
        pad_lead_d = 1'b0;
        final_d    = 1'b1;
        state_d    = ISSUE;
      end

      default: state_d = IDLE;
    endcase

    // The visible block only changes when a new block enters ISSUE.
    if (state_d == ISSUE && state_q != ISSUE) begin
      block_d = work_d;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.block       = block_q;
  assign bus.block_valid = block_valid_q;
  assign bus.block_first = block_first_q;
  assign bus.msg_done    = msg_done_q;

`ifdef SHA512_PAD_ERR_EN
  logic       err_q;
  logic [8:0] stall_q;
  logic       stalled;

  assign stalled = bus.in_valid && !in_ready_c && (state_q == ISSUE || state_q == PAD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      if (!stalled) begin
        stall_q <= '0;
      end else if (stall_q != 9'(SHA512_ERR_STALL_LIMIT)) begin
        stall_q <= stall_q + 9'd1;
      end
      if ((accept && bus.in_last && bus.in_bytes > 7'd64) ||
          (stalled && stall_q == 9'(SHA512_ERR_STALL_LIMIT))) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_sha512_padder.sv
// Self-checking bench for sha512_padder: directed length table, random messages, stall and reset cases.
module tb_sha512_padder;

  typedef struct {
    logic [1023:0] blk;
    logic          first;
    logic          done;
  } exp_t;

  typedef struct {
    int          len;
    int          nBlocks;
    logic [63:0] lenBits;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sha512_padder_if bus ();

  sha512_padder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad = 0;

  exp_t        expQ[$];
  logic [7:0]  msgBytes[$];
  int          doneCount = 0;
  int          pulsesInMsg = 0;
  int          lastPulses = 0;
  logic [127:0]  lastLenField = '0;
  logic [1023:0] lastBlock = '0;
  int          sinceLast = 100;
  logic        autoEngine = 1'b1;
  logic        manualReady = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic checkBlock(input string name, input logic [1023:0] actual, input logic [1023:0] expected);
    int w;
    total++;
    if (actual !== expected) begin
      bad++;
      w = 0;
      for (int i = 15; i >= 0; i--) begin
        if (actual[64*i +: 64] !== expected[64*i +: 64]) begin
          w = i;
          break;
        end
      end
      $display("[TB] FAIL %s: word %0d got %h, want %h", name, 15 - w, actual[64*w +: 64], expected[64*w +: 64]);
    end
  endtask

  task automatic noteTimeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out, got no response, want completion", name);
  endtask

  // Reference: message || 0x80 || zeros until 112 mod 128 || 128-bit bit length.
  function automatic void buildExpected();
    logic [7:0]     p[$];
    longint unsigned bits;
    int             nb;
    exp_t           e;
    p = msgBytes;
    p.push_back(8'h80);
    while (p.size() % 128 != 112) p.push_back(8'h00);
    bits = longint'(msgBytes.size()) * 8;
    for (int i = 0; i < 16; i++) p.push_back(i < 8 ? 8'h00 : 8'(bits >> (8 * (15 - i))));
    nb = p.size() / 128;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 128; j++) e.blk[1023 - 8*j -: 8] = p[128*b + j];
      e.first = (b == 0);
      e.done  = (b == nb - 1);
      expQ.push_back(e);
    end
  endfunction

  function automatic int numLines();
    return (msgBytes.size() == 0) ? 1 : (msgBytes.size() + 63) / 64;
  endfunction

  function automatic logic [511:0] lineData(input int k, input int n);
    logic [511:0] d;
    for (int i = 0; i < 64; i++) d[511 - 8*i -: 8] = (i < n) ? msgBytes[64*k + i] : 8'($urandom);
    return d;
  endfunction

  task automatic sendLine(input logic [511:0] data, input logic last, input logic [6:0] nb);
    int  waitc = 0;
    bit  done = 0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk);
    #1;
    bus.in_data  = data;
    bus.in_last  = last;
    bus.in_bytes = nb;
    bus.in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      @(posedge clk);
      #1;
      if (!done) begin
        waitc++;
        if (waitc > 3000) begin
          noteTimeout("line_accept");
          break;
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic sendLines(input int from, input int upto);
    int nl = numLines();
    int n;
    for (int k = from; k < upto; k++) begin
      n = (k == nl - 1) ? msgBytes.size() - 64*k : 64;
      sendLine(lineData(k, n), k == nl - 1, (k == nl - 1) ? 7'(n) : 7'($urandom_range(0, 127)));
    end
  endtask

  task automatic applyStimulus();
    buildExpected();
    sendLines(0, numLines());
  endtask

  task automatic waitDone(input int prev);
    int c = 0;
    while (doneCount == prev && c < 3000) begin
      @(posedge clk);
      c++;
    end
    if (doneCount == prev) noteTimeout("msg_done");
  endtask

  task automatic randomMessage(input int len);
    msgBytes.delete();
    for (int i = 0; i < len; i++) msgBytes.push_back(8'($urandom));
  endtask

  // Hash-engine stand-in: goes busy for a random time after every block.
  initial begin
    int busy = 0;
    bus.core_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (autoEngine) begin
        if (bus.block_valid) begin
          bus.core_ready = 1'b0;
          busy = $urandom_range(0, 6);
        end else if (busy > 0) begin
          busy--;
        end else begin
          bus.core_ready = 1'b1;
        end
      end else begin
        bus.core_ready = manualReady;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      sinceLast   = 100;
      pulsesInMsg = 0;
    end else begin
      sinceLast++;
      if (bus.block_valid) begin
        checkOutput("guard_gap", 128'(sinceLast > 3), 128'(1));
        sinceLast = 0;
        pulsesInMsg++;
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_block: got a block, want none");
        end else begin
          e = expQ.pop_front();
          checkBlock("block", {bus.block[1], bus.block[0]}, e.blk);
          checkOutput("first_done", {bus.block_first, bus.msg_done}, {e.first, e.done});
        end
        if (bus.msg_done) begin
          lastPulses   = pulsesInMsg;
          pulsesInMsg  = 0;
          lastLenField = bus.block[0][127:0];
          lastBlock    = {bus.block[1], bus.block[0]};
          doneCount++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t          tbl[11];
    logic [1023:0] abcBlk;
    int            prev;
    int            stallViol;

    tbl[0]  = '{0,   1, 64'h0};
    tbl[1]  = '{3,   1, 64'h18};
    tbl[2]  = '{64,  1, 64'h200};
    tbl[3]  = '{111, 1, 64'h378};
    tbl[4]  = '{112, 2, 64'h380};
    tbl[5]  = '{119, 2, 64'h3b8};
    tbl[6]  = '{128, 2, 64'h400};
    tbl[7]  = '{200, 2, 64'h640};
    tbl[8]  = '{240, 3, 64'h780};
    tbl[9]  = '{255, 3, 64'h7f8};
    tbl[10] = '{256, 3, 64'h800};
    abcBlk = {32'h61626380, 480'h0, 504'h0, 8'h18};

    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_bytes = '0;
    reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_flags", {bus.in_ready, bus.block_valid, bus.block_first, bus.msg_done, bus.err}, 128'(0));
    checkBlock("reset_block", {bus.block[1], bus.block[0]}, '0);
    reset_n = 1'b1;

    for (int v = 0; v < 11; v++) begin
      if (tbl[v].len == 3) begin
        msgBytes.delete();
        msgBytes.push_back(8'h61);
        msgBytes.push_back(8'h62);
        msgBytes.push_back(8'h63);
      end else begin
        randomMessage(tbl[v].len);
      end
      prev = doneCount;
      applyStimulus();
      waitDone(prev);
      checkOutput($sformatf("nblocks_len%0d", tbl[v].len), 128'(lastPulses), 128'(tbl[v].nBlocks));
      checkOutput($sformatf("lenfield_len%0d", tbl[v].len), lastLenField, {64'h0, tbl[v].lenBits});
      if (tbl[v].len == 3) checkBlock("abc_block", lastBlock, abcBlk);
    end

    // Engine held busy while a block waits in ISSUE.
    autoEngine  = 1'b0;
    manualReady = 1'b0;
    repeat (2) @(posedge clk);
    randomMessage(200);
    prev = doneCount;
    buildExpected();
    sendLines(0, 2);
    stallViol = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.block_valid || bus.in_ready) stallViol++;
    end
    checkOutput("stall_quiet", 128'(stallViol), 128'(0));
    manualReady = 1'b1;
    @(posedge clk);
    #2;
    @(negedge clk);
    checkOutput("issue_wait", 128'(bus.block_valid), 128'(0));
    @(negedge clk);
    checkOutput("issue_pulse", 128'(bus.block_valid), 128'(1));
    autoEngine = 1'b1;
    sendLines(2, numLines());
    waitDone(prev);
    checkOutput("stall_nblocks", 128'(lastPulses), 128'(2));

    // Reset in the middle of a message, then "abc" must come out clean.
    randomMessage(128);
    sendLines(0, 1);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midreset_flags", {bus.in_ready, bus.block_valid, bus.block_first, bus.msg_done, bus.err}, 128'(0));
    checkBlock("midreset_block", {bus.block[1], bus.block[0]}, '0);
    reset_n = 1'b1;
    msgBytes.delete();
    msgBytes.push_back(8'h61);
    msgBytes.push_back(8'h62);
    msgBytes.push_back(8'h63);
    prev = doneCount;
    applyStimulus();
    waitDone(prev);
    checkBlock("abc_after_reset", lastBlock, abcBlk);
    checkOutput("abc_after_reset_n", 128'(lastPulses), 128'(1));

    for (int r = 0; r < 16; r++) begin
      randomMessage($urandom_range(0, 400));
      prev = doneCount;
      applyStimulus();
      waitDone(prev);
    end

    repeat (10) @(posedge clk);
    checkOutput("exp_queue_empty", 128'(expQ.size()), 128'(0));
    checkOutput("err_idle", 128'(bus.err), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
